// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds dispatched ALU micro-ops until both source
// operands are available, snoops the CDB for wakeups, and issues the
// lowest-index ready entry each cycle to the combinational ALU downstream.
// Optional macro ALU_RS_WAKEUP_ISSUE_EN: an operand arriving on the CDB this
// cycle counts as ready, with the operand output muxed from cdb_data.

package alu_rs_pkg;
  localparam int unsigned RD_W = 6;

  typedef struct packed {
    logic [2:0]      aluop;
    logic [2:0]      cmpop;
    logic            alu_m1_sel;
    logic [2:0]      alu_m2_sel;
    logic [31:0]     pc;
    logic [31:0]     imm;
    logic [RD_W-1:0] rd;
  } rs_data_pkt_t;
endpackage

module alu_reservation_station
  import alu_rs_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned PREG_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              disp_valid,
  output logic              disp_ready,
  input  rs_data_pkt_t      disp_pkt,
  input  logic [PREG_W-1:0] disp_ps1,
  input  logic              disp_ps1_rdy,
  input  logic [31:0]       disp_ps1_data,
  input  logic [PREG_W-1:0] disp_ps2,
  input  logic              disp_ps2_rdy,
  input  logic [31:0]       disp_ps2_data,
  input  logic              cdb_valid,
  input  logic [PREG_W-1:0] cdb_tag,
  input  logic [31:0]       cdb_data,
  output logic              issue_valid,
  input  logic              issue_ready,
  output rs_data_pkt_t      rs_input_pkt,
  output logic [31:0]       rs1_data,
  output logic [31:0]       rs2_data
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0]  r_valid;
  logic [DEPTH-1:0]  r_rdy1;
  logic [DEPTH-1:0]  r_rdy2;
  rs_data_pkt_t      r_pkt   [DEPTH];
  logic [PREG_W-1:0] r_tag1  [DEPTH];
  logic [PREG_W-1:0] r_tag2  [DEPTH];
  logic [31:0]       r_data1 [DEPTH];
  logic [31:0]       r_data2 [DEPTH];

  logic [DEPTH-1:0]  w_hit1;
  logic [DEPTH-1:0]  w_hit2;
  logic [DEPTH-1:0]  w_ready;
  logic              w_free_found;
  logic [IDX_W-1:0]  w_free_idx;
  logic              w_sel_found;
  logic [IDX_W-1:0]  w_sel_idx;
  logic              w_disp_fire;
  logic              w_issue_fire;
  logic              w_cap1;
  logic              w_cap2;

  // Per-entry CDB tag match on still-missing operands, and readiness
  always_comb begin
    w_hit1  = '0;
    w_hit2  = '0;
    w_ready = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_hit1[i] = cdb_valid && !r_rdy1[i] && (r_tag1[i] == cdb_tag);
      w_hit2[i] = cdb_valid && !r_rdy2[i] && (r_tag2[i] == cdb_tag);
`ifdef ALU_RS_WAKEUP_ISSUE_EN
      w_ready[i] = r_valid[i] && (r_rdy1[i] || w_hit1[i]) && (r_rdy2[i] || w_hit2[i]);
`else
      w_ready[i] = r_valid[i] && r_rdy1[i] && r_rdy2[i];
`endif
    end
  end

  // Lowest-index free slot for allocation
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!w_free_found && !r_valid[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = IDX_W'(i);
      end
    end
  end

  // Lowest-index ready entry for issue
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!w_sel_found && w_ready[i]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = IDX_W'(i);
      end
    end
  end

  assign disp_ready   = w_free_found;
  assign issue_valid  = w_sel_found;
  assign w_disp_fire  = disp_valid && disp_ready;
  assign w_issue_fire = issue_valid && issue_ready;
  assign w_cap1       = cdb_valid && !disp_ps1_rdy && (cdb_tag == disp_ps1);
  assign w_cap2       = cdb_valid && !disp_ps2_rdy && (cdb_tag == disp_ps2);
  assign rs_input_pkt = r_pkt[w_sel_idx];

`ifdef ALU_RS_WAKEUP_ISSUE_EN
  assign rs1_data = r_rdy1[w_sel_idx] ? r_data1[w_sel_idx] : cdb_data;
  assign rs2_data = r_rdy2[w_sel_idx] ? r_data2[w_sel_idx] : cdb_data;
`else
  assign rs1_data = r_data1[w_sel_idx];
  assign rs2_data = r_data2[w_sel_idx];
`endif

  // Entry valid bits: reset/flush clear, issue frees, dispatch allocates
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_valid <= '0;
    end else begin
      if (w_issue_fire) r_valid[w_sel_idx] <= 1'b0;
      if (w_disp_fire)  r_valid[w_free_idx] <= 1'b1;
    end
  end

  // Entry payload: CDB wakeup of waiting operands and dispatch write
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && w_hit1[i]) begin
        r_rdy1[i]  <= 1'b1;
        r_data1[i] <= cdb_data;
      end
      if (r_valid[i] && w_hit2[i]) begin
        r_rdy2[i]  <= 1'b1;
        r_data2[i] <= cdb_data;
      end
    end
    if (w_disp_fire) begin
      r_pkt[w_free_idx]   <= disp_pkt;
      r_tag1[w_free_idx]  <= disp_ps1;
      r_tag2[w_free_idx]  <= disp_ps2;
      r_rdy1[w_free_idx]  <= disp_ps1_rdy || w_cap1;
      r_rdy2[w_free_idx]  <= disp_ps2_rdy || w_cap2;
      r_data1[w_free_idx] <= disp_ps1_rdy ? disp_ps1_data : cdb_data;
      r_data2[w_free_idx] <= disp_ps2_rdy ? disp_ps2_data : cdb_data;
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Self-checking bench for alu_reservation_station: expected issues are queued
// at stimulus time and compared in order as the station issues them.
// Honours ALU_RS_WAKEUP_ISSUE_EN for the zero-latency wakeup timing.

module tb_alu_reservation_station;
  import alu_rs_pkg::*;

  localparam int unsigned PREG_W = 6;

  typedef struct packed {
    rs_data_pkt_t pkt;
    logic [31:0]  d1;
    logic [31:0]  d2;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              disp_valid;
  logic              disp_ready;
  rs_data_pkt_t      disp_pkt;
  logic [PREG_W-1:0] disp_ps1;
  logic              disp_ps1_rdy;
  logic [31:0]       disp_ps1_data;
  logic [PREG_W-1:0] disp_ps2;
  logic              disp_ps2_rdy;
  logic [31:0]       disp_ps2_data;
  logic              cdb_valid;
  logic [PREG_W-1:0] cdb_tag;
  logic [31:0]       cdb_data;
  logic              issue_valid;
  logic              issue_ready;
  rs_data_pkt_t      rs_input_pkt;
  logic [31:0]       rs1_data;
  logic [31:0]       rs2_data;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];

  alu_reservation_station #(.DEPTH(8), .PREG_W(PREG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_pkt(disp_pkt),
    .disp_ps1(disp_ps1), .disp_ps1_rdy(disp_ps1_rdy), .disp_ps1_data(disp_ps1_data),
    .disp_ps2(disp_ps2), .disp_ps2_rdy(disp_ps2_rdy), .disp_ps2_data(disp_ps2_data),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .rs_input_pkt(rs_input_pkt), .rs1_data(rs1_data), .rs2_data(rs2_data)
  );

  always #5 clk = ~clk;

  // Scoreboard: every accepted issue must match the next expected op
  always @(negedge clk) begin
    if (!rst && issue_valid && issue_ready) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL issue_unexpected: got pkt=%h rs1=%h rs2=%h, required no issue",
                 rs_input_pkt, rs1_data, rs2_data);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if ({rs_input_pkt, rs1_data, rs2_data} !== e) begin
          n_fail++;
          $display("FAIL issue_data: got pkt=%h rs1=%h rs2=%h, required pkt=%h rs1=%h rs2=%h",
                   rs_input_pkt, rs1_data, rs2_data, e.pkt, e.d1, e.d2);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic rs_data_pkt_t rand_pkt();
    rs_data_pkt_t p;
    p = rs_data_pkt_t'({$urandom, $urandom, $urandom});
    return p;
  endfunction

  // Present one op on the dispatch port for the current cycle
  task automatic drive_disp(input rs_data_pkt_t p,
                            input logic [PREG_W-1:0] t1, input logic r1, input logic [31:0] d1,
                            input logic [PREG_W-1:0] t2, input logic r2, input logic [31:0] d2);
    disp_valid    = 1'b1;
    disp_pkt      = p;
    disp_ps1      = t1;
    disp_ps1_rdy  = r1;
    disp_ps1_data = d1;
    disp_ps2      = t2;
    disp_ps2_rdy  = r2;
    disp_ps2_data = d2;
  endtask

  task automatic idle_inputs();
    disp_valid = 1'b0;
    cdb_valid  = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    issue_ready = 1'b1;
    disp_pkt = '0; disp_ps1 = '0; disp_ps2 = '0;
    disp_ps1_rdy = 1'b0; disp_ps2_rdy = 1'b0;
    disp_ps1_data = '0; disp_ps2_data = '0;
    cdb_tag = '0; cdb_data = '0;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (disp_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_disp_ready: got %b, required 1", disp_ready);
    end
    n_checks++;
    if (issue_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_issue_valid: got %b, required 0", issue_valid);
    end
    step();
  endtask

  task automatic test_basic_issue();
    rs_data_pkt_t p = rand_pkt();
    issue_ready = 1'b1;
    sb_q.push_back('{p, 32'd5, 32'd7});
    drive_disp(p, 6'd3, 1'b1, 32'd5, 6'd4, 1'b1, 32'd7);
    step();
    disp_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (issue_valid !== 1'b1) begin
      n_fail++; $display("FAIL basic_issue_valid: got %b, required 1", issue_valid);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (issue_valid !== 1'b0 || disp_ready !== 1'b1) begin
      n_fail++; $display("FAIL basic_empty: got issue_valid=%b disp_ready=%b, required 0/1",
                         issue_valid, disp_ready);
    end
    step();
  endtask

  task automatic test_wakeup();
    rs_data_pkt_t p = rand_pkt();
    issue_ready = 1'b1;
    drive_disp(p, 6'd12, 1'b0, 32'h0, 6'd0, 1'b1, 32'h0);
    step();
    disp_valid = 1'b0;
    step();
    sb_q.push_back('{p, 32'hDEADBEEF, 32'h0});
    cdb_valid = 1'b1; cdb_tag = 6'd12; cdb_data = 32'hDEADBEEF;
    @(negedge clk);
    n_checks++;
`ifdef ALU_RS_WAKEUP_ISSUE_EN
    if (issue_valid !== 1'b1) begin
      n_fail++; $display("FAIL wakeup_same_cycle: got %b, required 1", issue_valid);
    end
`else
    if (issue_valid !== 1'b0) begin
      n_fail++; $display("FAIL wakeup_early: got %b, required 0", issue_valid);
    end
`endif
    step();
    cdb_valid = 1'b0;
    @(negedge clk);
    n_checks++;
`ifdef ALU_RS_WAKEUP_ISSUE_EN
    if (issue_valid !== 1'b0) begin
      n_fail++; $display("FAIL wakeup_after: got %b, required 0", issue_valid);
    end
`else
    if (issue_valid !== 1'b1) begin
      n_fail++; $display("FAIL wakeup_issue: got %b, required 1", issue_valid);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (issue_valid !== 1'b0) begin
      n_fail++; $display("FAIL wakeup_after: got %b, required 0", issue_valid);
    end
`endif
    step();
  endtask

  task automatic test_full();
    rs_data_pkt_t p [8];
    issue_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      p[i] = rand_pkt();
      drive_disp(p[i], 6'(20 + i), 1'b0, 32'h0, 6'd0, 1'b1, 32'h0);
      step();
    end
    disp_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (disp_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_disp_ready: got %b, required 0", disp_ready);
    end
    // A fully ready op offered while full must be dropped (never issues)
    drive_disp(rand_pkt(), 6'd0, 1'b1, 32'h1, 6'd0, 1'b1, 32'h2);
    step();
    disp_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (issue_valid !== 1'b0 || disp_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_extra_ignored: got issue_valid=%b disp_ready=%b, required 0/0",
                         issue_valid, disp_ready);
    end
    sb_q.push_back('{p[3], 32'h3333_0003, 32'h0});
    cdb_valid = 1'b1; cdb_tag = 6'd23; cdb_data = 32'h3333_0003;
    step();
    cdb_valid = 1'b0;
`ifndef ALU_RS_WAKEUP_ISSUE_EN
    @(negedge clk);
    n_checks++;
    if (disp_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_before_issue: got %b, required 0", disp_ready);
    end
    step();
`endif
    @(negedge clk);
    n_checks++;
    if (disp_ready !== 1'b1) begin
      n_fail++; $display("FAIL full_slot_freed: got %b, required 1", disp_ready);
    end
    do_flush();
  endtask

  task automatic test_dispatch_capture();
    rs_data_pkt_t p = rand_pkt();
    issue_ready = 1'b1;
    sb_q.push_back('{p, 32'h0000_0011, 32'hCAFE_F00D});
    drive_disp(p, 6'd1, 1'b1, 32'h0000_0011, 6'd9, 1'b0, 32'hBAD0_BAD0);
    cdb_valid = 1'b1; cdb_tag = 6'd9; cdb_data = 32'hCAFE_F00D;
    step();
    disp_valid = 1'b0;
    cdb_valid  = 1'b0;
    @(negedge clk);
    n_checks++;
    if (issue_valid !== 1'b1) begin
      n_fail++; $display("FAIL capture_issue: got %b, required 1", issue_valid);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (issue_valid !== 1'b0) begin
      n_fail++; $display("FAIL capture_after: got %b, required 0", issue_valid);
    end
    step();
  endtask

  task automatic test_back_to_back();
    rs_data_pkt_t p [6];
    logic [31:0]  a [6];
    issue_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      p[i] = rand_pkt();
      a[i] = $urandom;
      if (i == 2 || i == 5) begin
        sb_q.push_back('{p[i], a[i], 32'(i)});
        drive_disp(p[i], 6'd1, 1'b1, a[i], 6'd2, 1'b1, 32'(i));
      end else begin
        drive_disp(p[i], 6'd50, 1'b0, 32'h0, 6'd0, 1'b1, 32'h0);
      end
      step();
    end
    disp_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (issue_valid !== 1'b1 || rs_input_pkt !== p[2] || rs1_data !== a[2] || rs2_data !== 32'd2) begin
        n_fail++;
        $display("FAIL hold_stable: got v=%b pkt=%h rs1=%h rs2=%h, required v=1 pkt=%h rs1=%h rs2=%h",
                 issue_valid, rs_input_pkt, rs1_data, rs2_data, p[2], a[2], 32'd2);
      end
      step();
    end
    issue_ready = 1'b1;
    step();
    step();
    @(negedge clk);
    n_checks++;
    if (issue_valid !== 1'b0) begin
      n_fail++; $display("FAIL hold_drained: got %b, required 0", issue_valid);
    end
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL hold_order: got %0d pending, required 0", sb_q.size());
    end
    do_flush();
  endtask

  task automatic test_flush();
    issue_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_disp(rand_pkt(), 6'(40 + i), 1'b0, 32'h0, 6'd0, 1'b1, 32'h0);
      step();
    end
    drive_disp(rand_pkt(), 6'd0, 1'b1, 32'hF1, 6'd0, 1'b1, 32'hF2);
    flush = 1'b1;
    step();
    flush = 1'b0;
    disp_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (issue_valid !== 1'b0 || disp_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_clear: got issue_valid=%b disp_ready=%b, required 0/1",
                         issue_valid, disp_ready);
    end
    // Broadcast the flushed tags; nothing may wake up and issue
    for (int i = 0; i < 4; i++) begin
      cdb_valid = 1'b1; cdb_tag = 6'(40 + i); cdb_data = 32'(i);
      step();
      @(negedge clk);
      n_checks++;
      if (issue_valid !== 1'b0) begin
        n_fail++; $display("FAIL flush_stale_%0d: got issue_valid=%b, required 0", i, issue_valid);
      end
    end
    cdb_valid = 1'b0;
    step();
    step();
  endtask

  initial begin
    test_reset();
    test_basic_issue();
    test_wakeup();
    test_full();
    test_dispatch_capture();
    test_back_to_back();
    test_flush();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d pending, required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- Holds dispatched ALU-class micro-ops until both source operands are available.
- Captures operand values from the common data bus (CDB) as producers broadcast them.
- Issues one ready op per cycle, as rs_data_pkt_t plus rs1/rs2 values, to the combinational ALU directly downstream.
- Sits between rename/dispatch and the ALU functional unit; the ALU result returns to the CDB through the writeback arbiter.

Parameters:
- DEPTH, 8, number of entries (power of two, 2..32).
- PREG_W, 6, physical register tag width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  branch-mispredict flush; clears all entries.
- disp_valid  in  1  dispatch offers an op.
- disp_ready  out  1  station can accept an op this cycle.
- disp_pkt  in  $bits(rs_data_pkt_t)  op payload (aluop, cmpop, mux selects, pc, imm, rd tag).
- disp_ps1  in  PREG_W  source-1 physical tag.
- disp_ps1_rdy  in  1  source-1 value is already available.
- disp_ps1_data  in  32  source-1 value, valid when disp_ps1_rdy=1.
- disp_ps2  in  PREG_W  source-2 physical tag.
- disp_ps2_rdy  in  1  source-2 value is already available.
- disp_ps2_data  in  32  source-2 value, valid when disp_ps2_rdy=1.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  PREG_W  broadcast destination tag.
- cdb_data  in  32  broadcast value.
- issue_valid  out  1  rs_input_pkt/rs1_data/rs2_data hold a ready op.
- issue_ready  in  1  ALU/writeback accepts the op.
- rs_input_pkt  out  $bits(rs_data_pkt_t)  payload to ALU.
- rs1_data  out  32  operand 1 to ALU.
- rs2_data  out  32  operand 2 to ALU.

Behaviour:
- Entry state: valid, pkt, per source {tag, rdy, data}. Reset and flush clear every valid bit at the clock edge; payload fields are don't-care.
- Reset values: disp_ready=1 (empty), issue_valid=0. rs_input_pkt, rs1_data and rs2_data are don't-care while issue_valid=0.
- disp_ready = not all entries valid. It is computed from registered state only; a same-cycle issue does not free a slot for that cycle's dispatch.
- Allocation: on disp_valid && disp_ready, write the lowest-index free entry at the edge. Entry is visible from cycle N+1.
- Dispatch-cycle capture: if cdb_valid and cdb_tag equals disp_psX with disp_psX_rdy=0, store rdy=1 and data=cdb_data. This prevents lost wakeups.
- Wakeup: each cycle, for every valid entry with srcX.rdy=0 and tag==cdb_tag while cdb_valid, set rdy=1 and data=cdb_data at the edge. All matching entries and both sources wake simultaneously.
- Select: issue candidate is the lowest-index valid entry with both rdy=1. issue_valid=1 iff one exists. Outputs are driven combinationally from that entry.
- Issue: on issue_valid && issue_ready, clear that entry's valid at the edge.
- Hold: with issue_valid=1 and issue_ready=0, outputs are held stable. The selected entry does not change unless a lower-index entry becomes ready; a lower-index ready entry may legally preempt.
- Latency: dispatch of an op with both operands ready at edge N gives issue_valid in cycle N+1. Final operand wakeup at edge N gives issue_valid in cycle N+1.
- Simultaneous dispatch, issue and wakeup in one cycle are all honoured independently.
- Flush outranks dispatch: a dispatch in the flush cycle is dropped. rst outranks everything.
- Tag 0 is never broadcast: x0 sources arrive with rdy=1, data=0.

Optional Feature:
- Macro: ALU_RS_WAKEUP_ISSUE_EN.
- Defined: an entry whose only missing operand matches the current CDB broadcast counts as ready this cycle. The matching operand output is muxed from cdb_data, giving wakeup-to-issue latency of 0 cycles. If issued, the entry is freed and no rdy write is needed.
- Undefined: readiness uses registered rdy bits only; wakeup-to-issue latency is 1 cycle.

Test Plan:
- Reset, then dispatch add with ps1_rdy=1 data 5 and ps2_rdy=1 data 7, issue_ready=1 -> issue_valid in the next cycle, rs1_data=5, rs2_data=7; station is empty afterwards.
- Dispatch op with ps1=12 not ready; two cycles later CDB tag 12 data 0xDEADBEEF -> issue_valid one cycle after the broadcast (zero cycles with macro), rs1_data=0xDEADBEEF.
- Fill all 8 entries with unready ops -> disp_ready=0. An extra disp_valid is ignored. Broadcast a tag for entry 3 and issue it -> disp_ready=1 the following cycle.
- CDB tag 9 broadcast in the same cycle as a dispatch with ps2=9 unready -> entry captures the value and issues next cycle with rs2_data equal to the broadcast value.
- Entries 2 and 5 both ready, issue_ready=0 for 3 cycles -> outputs stable on entry 2. Then issue_ready=1 -> entry 2 issues, then entry 5 next cycle.
- Flush asserted with 4 entries valid and a concurrent dispatch -> next cycle issue_valid=0, disp_ready=1, and no stale op ever issues.
